bcd_timer_core: RTL and testbench

BCD_TIMER_CORE -- requirements
Module: bcd_timer_core

---
 rtl/bcd_timer_core.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_bcd_timer_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_core.sv
// BCD up/down timer core: prescaled count steps, pause/expire control,
// a small circular lap buffer with hold and recall for the display path.
module bcd_timer_core #(
    parameter int DIGITS    = 4,
    parameter int TICK_DIV  = 5000000,
    parameter int FAST_MULT = 5,
    parameter int LAP_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             clear,
    input  logic                             lap,
    input  logic                             recall,
    input  logic                             up,
    input  logic                             set,
    output logic [4*DIGITS-1:0]              value,
    output logic [4*DIGITS-1:0]              disp,
    output logic                             running,
    output logic                             flashing,
    output logic                             tick,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count
);

    localparam int W    = 4 * DIGITS;
    localparam int CW   = $clog2(LAP_DEPTH + 1);
    localparam int PTRW = $clog2(LAP_DEPTH);
    localparam int PW   = $clog2(TICK_DIV) + 1;

    localparam logic [W-1:0]    ZERO_V   = {W{1'b0}};
    localparam logic [W-1:0]    ONE_V    = W'(1'b1);
    localparam logic [PW-1:0]   ZERO_P   = {PW{1'b0}};
    localparam logic [PW-1:0]   INC1_P   = PW'(1'b1);
    localparam logic [PW-1:0]   FAST_P   = PW'(FAST_MULT);
    localparam logic [PW-1:0]   DIV_P    = PW'(TICK_DIV);
    localparam logic [CW-1:0]   ZERO_C   = {CW{1'b0}};
    localparam logic [CW-1:0]   ONE_C    = CW'(1'b1);
    localparam logic [CW-1:0]   FULL_C   = CW'(LAP_DEPTH);
    localparam logic [PTRW-1:0] ZERO_PTR = {PTRW{1'b0}};
    localparam logic [PTRW-1:0] ONE_PTR  = PTRW'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // BCD increment with ripple carry; all-9s wraps to all-0s.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // BCD decrement with ripple borrow; all-0s wraps to all-9s.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    borrow      = 1'b1;
                end else if (v[4*i +: 4] > 4'd9) begin
                    r[4*i +: 4] = 4'd8;
                    borrow      = 1'b0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [W-1:0]    value_r, value_nxt_s, disp_r, disp_nxt_s, step_val_s;
    logic [PW-1:0]   presc_r, presc_nxt_s, presc_sum_s;
    logic            dir_r, dir_nxt_s, fast_r, fast_nxt_s;
    logic            hold_r, hold_nxt_s, tick_r, tick_nxt_s;
    logic            running_r, running_nxt_s, flashing_r, flashing_nxt_s;
    logic [CW-1:0]   view_r, view_nxt_s, lap_cnt_r, lap_cnt_nxt_s;
    logic [PTRW-1:0] wr_ptr_r, wr_ptr_nxt_s, oldest_s, slot_s, latest_s;
    logic [W-1:0]    lap_mem_r [LAP_DEPTH];
    logic            in_run_s, clr_acc_s, stop_acc_s, start_ok_s, start_acc_s;
    logic            lap_acc_s, recall_acc_s, step_s, expire_s;

    // Decode which command wins this cycle and evaluate the prescaler sum.
    always_comb begin
        in_run_s   = (state_r == ST_RUN);
        clr_acc_s  = clear && !in_run_s;
        stop_acc_s = stop && in_run_s;
        start_ok_s = 1'b0;
        case (state_r)
            ST_IDLE:   start_ok_s = up || set || (value_r != ZERO_V);
            ST_PAUSED: start_ok_s = 1'b1;
            default:   start_ok_s = 1'b0;
        endcase
        // A stop in the same cycle always blocks start, even outside RUN.
        start_acc_s  = start && start_ok_s && !clr_acc_s && !stop;
        lap_acc_s    = lap && in_run_s && !stop;
        recall_acc_s = recall && !in_run_s && (lap_cnt_r != ZERO_C)
                       && !clr_acc_s && !stop && !start_acc_s;
        presc_sum_s  = presc_r + (fast_r ? FAST_P : INC1_P);
        step_s       = in_run_s && !stop && (presc_sum_s >= DIV_P);
        step_val_s   = dir_r ? bcd_inc(value_r) : bcd_dec(value_r);
        // Only a slow down-count reaching zero expires; fast mode wraps.
        expire_s     = step_s && !dir_r && !fast_r && (value_r == ONE_V);
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) state_nxt_s = ST_RUN;
                else             state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (stop_acc_s)    state_nxt_s = ST_PAUSED;
                else if (expire_s) state_nxt_s = ST_EXPIRED;
                else               state_nxt_s = ST_RUN;
            end
            ST_PAUSED: begin
                if (clr_acc_s)        state_nxt_s = ST_IDLE;
                else if (start_acc_s) state_nxt_s = ST_RUN;
                else                  state_nxt_s = ST_PAUSED;
            end
            ST_EXPIRED: begin
                if (clr_acc_s) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_EXPIRED;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State flag outputs, computed from the next state and then registered.
    always_comb begin
        running_nxt_s  = (state_nxt_s == ST_RUN);
        flashing_nxt_s = (state_nxt_s == ST_EXPIRED);
    end

    // Datapath next values: count, prescaler, lap bookkeeping, hold/view.
    always_comb begin
        value_nxt_s   = value_r;
        presc_nxt_s   = presc_r;
        dir_nxt_s     = dir_r;
        fast_nxt_s    = fast_r;
        hold_nxt_s    = hold_r;
        view_nxt_s    = view_r;
        wr_ptr_nxt_s  = wr_ptr_r;
        lap_cnt_nxt_s = lap_cnt_r;
        tick_nxt_s    = 1'b0;
        if (clr_acc_s) begin
            value_nxt_s   = ZERO_V;
            presc_nxt_s   = ZERO_P;
            hold_nxt_s    = 1'b0;
            view_nxt_s    = ZERO_C;
            wr_ptr_nxt_s  = ZERO_PTR;
            lap_cnt_nxt_s = ZERO_C;
        end else if (start_acc_s) begin
            dir_nxt_s  = up;
            fast_nxt_s = set;
            hold_nxt_s = 1'b0;
            view_nxt_s = ZERO_C;
            // Resuming from PAUSED keeps the partial prescaler count.
            if (state_r == ST_IDLE) presc_nxt_s = ZERO_P;
            else                    presc_nxt_s = presc_r;
        end else if (in_run_s && !stop) begin
            if (step_s) begin
                presc_nxt_s = ZERO_P;
                tick_nxt_s  = 1'b1;
                if (expire_s) value_nxt_s = ZERO_V;
                else          value_nxt_s = step_val_s;
            end else begin
                presc_nxt_s = presc_sum_s;
            end
            if (lap_acc_s) begin
                wr_ptr_nxt_s  = wr_ptr_r + ONE_PTR;
                lap_cnt_nxt_s = (lap_cnt_r == FULL_C) ? lap_cnt_r : lap_cnt_r + ONE_C;
                hold_nxt_s    = 1'b1;
            end else begin
                hold_nxt_s = hold_r;
            end
        end else if (recall_acc_s) begin
            // After the newest lap the view returns to the live count.
            if (view_r == lap_cnt_r) begin
                view_nxt_s = ZERO_C;
                hold_nxt_s = 1'b0;
            end else begin
                view_nxt_s = view_r + ONE_C;
            end
        end else begin
            view_nxt_s = view_r;
        end
    end

    // Display source: recalled lap, held newest lap, or the live count.
    always_comb begin
        oldest_s = wr_ptr_r - PTRW'(lap_cnt_r);
        slot_s   = oldest_s + PTRW'(view_nxt_s) - ONE_PTR;
        latest_s = wr_ptr_r - ONE_PTR;
        if (view_nxt_s != ZERO_C) begin
            disp_nxt_s = lap_mem_r[slot_s];
        end else if (hold_nxt_s) begin
            disp_nxt_s = lap_acc_s ? value_r : lap_mem_r[latest_s];
        end else begin
            disp_nxt_s = value_nxt_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            value_r    <= ZERO_V;
            disp_r     <= ZERO_V;
            presc_r    <= ZERO_P;
            dir_r      <= 1'b1;
            fast_r     <= 1'b0;
            hold_r     <= 1'b0;
            view_r     <= ZERO_C;
            wr_ptr_r   <= ZERO_PTR;
            lap_cnt_r  <= ZERO_C;
            tick_r     <= 1'b0;
            running_r  <= 1'b0;
            flashing_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            value_r    <= value_nxt_s;
            disp_r     <= disp_nxt_s;
            presc_r    <= presc_nxt_s;
            dir_r      <= dir_nxt_s;
            fast_r     <= fast_nxt_s;
            hold_r     <= hold_nxt_s;
            view_r     <= view_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            lap_cnt_r  <= lap_cnt_nxt_s;
            tick_r     <= tick_nxt_s;
            running_r  <= running_nxt_s;
            flashing_r <= flashing_nxt_s;
        end
    end

    // Lap storage; contents are only meaningful while lap_count is nonzero.
    always_ff @(posedge clk) begin
        if (!reset && lap_acc_s) begin
            lap_mem_r[wr_ptr_r] <= value_r;
        end
    end

    assign value     = value_r;
    assign disp      = disp_r;
    assign running   = running_r;
    assign flashing  = flashing_r;
    assign tick      = tick_r;
    assign lap_count = lap_cnt_r;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Scoreboard bench for bcd_timer_core with a small, fast configuration.
module tb_bcd_timer_core;

    localparam int DIGITS    = 4;
    localparam int TICK_DIV  = 4;
    localparam int FAST_MULT = 2;
    localparam int LAP_DEPTH = 4;
    localparam int CW        = $clog2(LAP_DEPTH + 1);

    localparam int K_VALUE = 0;
    localparam int K_DISP  = 1;
    localparam int K_RUN   = 2;
    localparam int K_FLASH = 3;
    localparam int K_TICK  = 4;
    localparam int K_LAPS  = 5;

    logic        clk = 1'b0;
    logic        reset, start, stop, clear, lap, recall, up, set;
    logic [15:0] value, disp;
    logic        running, flashing, tick;
    logic [CW-1:0] lap_count;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
        int          tag;
    } chk_t;

    chk_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tag_cnt  = 0;
    logic done     = 1'b0;

    bcd_timer_core #(
        .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .FAST_MULT(FAST_MULT), .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .lap(lap), .recall(recall), .up(up), .set(set),
        .value(value), .disp(disp), .running(running), .flashing(flashing),
        .tick(tick), .lap_count(lap_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_VALUE: return "value";
            K_DISP:  return "disp";
            K_RUN:   return "running";
            K_FLASH: return "flashing";
            K_TICK:  return "tick";
            K_LAPS:  return "lap_count";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [15:0] actual(input int k);
        case (k)
            K_VALUE: return value;
            K_DISP:  return disp;
            K_RUN:   return {15'd0, running};
            K_FLASH: return {15'd0, flashing};
            K_TICK:  return {15'd0, tick};
            K_LAPS:  return {{(16-CW){1'b0}}, lap_count};
            default: return 16'hxxxx;
        endcase
    endfunction

    // Queue an expectation for the outputs visible at the current cycle.
    task automatic want(input int k, input logic [15:0] exp);
        sb_q.push_back('{cyc, k, exp, tag_cnt});
        tag_cnt++;
    endtask

    // Drive one command strobe cycle; returns once the result is visible.
    task automatic cmd(input logic s, input logic p, input logic c, input logic l, input logic r);
        start = s; stop = p; clear = c; lap = l; recall = r;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0; recall = 1'b0;
    endtask

    task automatic wait_value(input logic [15:0] target, input int budget);
        int k;
        k = 0;
        while (value !== target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (value !== target) begin
            n_checks++;
            $display("FAIL wait_value: value=%h never reached %h within %0d cycles", value, target, budget);
        end
    endtask

    task automatic want_reset_state();
        want(K_VALUE, 16'h0000);
        want(K_DISP,  16'h0000);
        want(K_RUN,   16'd0);
        want(K_FLASH, 16'd0);
        want(K_TICK,  16'd0);
        want(K_LAPS,  16'd0);
    endtask

    // Monitor: compare every queued expectation once its cycle is reached.
    initial begin
        chk_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            #1;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e   = sb_q.pop_front();
                act = actual(e.kind);
                n_checks++;
                if (act === e.exp) n_pass++;
                else $display("FAIL %s #%0d: got %h expected %h", kname(e.kind), e.tag, act, e.exp);
            end
        end
    end

    // Watchdog bounding the whole run.
    initial begin
        repeat (30000) @(posedge clk);
        if (!done) begin
            $display("FAIL watchdog: run exceeded cycle budget");
            $fatal(1, "watchdog expired");
        end
    end

    // Stimulus.
    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        lap = 1'b0; recall = 1'b0; up = 1'b1; set = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        want_reset_state();

        // Slow up-count: one step every 4 cycles.
        up = 1'b1; set = 1'b0;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want(K_RUN, 16'd1);
        want(K_VALUE, 16'h0000);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            want(K_TICK, (i % 4 == 0) ? 16'd1 : 16'd0);
            if (i == 20) want(K_VALUE, 16'h0005);
            if (i == 40) begin
                want(K_VALUE, 16'h0010);
                want(K_RUN, 16'd1);
            end
        end
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        want(K_RUN, 16'd0);
        want(K_VALUE, 16'h0010);

        // Fast up to 0099, pause, then slow carry into 0100.
        up = 1'b1; set = 1'b1;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_value(16'h0099, 400);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        want(K_VALUE, 16'h0099);
        want(K_RUN, 16'd0);
        up = 1'b1; set = 1'b0;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 3) want(K_VALUE, 16'h0099);
            if (i == 4) begin
                want(K_VALUE, 16'h0100);
                want(K_TICK, 16'd1);
            end
        end
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Down-count from 0002 to expiry.
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        want(K_VALUE, 16'h0000);
        up = 1'b1; set = 1'b1;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_value(16'h0002, 50);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        want(K_VALUE, 16'h0002);
        up = 1'b0; set = 1'b0;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                want(K_VALUE, 16'h0001);
                want(K_RUN, 16'd1);
            end
            if (i == 8) begin
                want(K_VALUE, 16'h0000);
                want(K_FLASH, 16'd1);
                want(K_RUN, 16'd0);
                want(K_TICK, 16'd1);
            end
        end
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want(K_FLASH, 16'd1);
        want(K_RUN, 16'd0);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        want(K_FLASH, 16'd0);
        want(K_RUN, 16'd0);

        // Start rejected: IDLE at zero, counting down slowly.
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want(K_RUN, 16'd0);

        // Fast down from zero wraps to 9999 without expiring.
        up = 1'b0; set = 1'b1;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want(K_RUN, 16'd1);
        @(negedge clk);
        want(K_VALUE, 16'h0000);
        @(negedge clk);
        want(K_VALUE, 16'h9999);
        want(K_FLASH, 16'd0);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        want(K_VALUE, 16'h9999);
        up = 1'b1; set = 1'b0;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        want(K_VALUE, 16'h0000);
        want(K_FLASH, 16'd0);
        want(K_RUN, 16'd1);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Laps: five captures into a four-entry buffer, then recall.
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        want(K_LAPS, 16'd0);
        up = 1'b1; set = 1'b0;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_value(16'h0003, 50);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        want(K_DISP, 16'h0003);
        want(K_LAPS, 16'd1);
        wait_value(16'h0005, 50);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_value(16'h0007, 50);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_value(16'h0009, 50);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_value(16'h0011, 50);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        want(K_LAPS, 16'd4);
        want(K_DISP, 16'h0011);
        wait_value(16'h0012, 50);
        want(K_DISP, 16'h0011);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        want(K_DISP, 16'h0011);
        cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        want(K_DISP, 16'h0005);
        cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        want(K_DISP, 16'h0007);
        cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        want(K_DISP, 16'h0009);
        cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        want(K_DISP, 16'h0011);
        cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        want(K_DISP, 16'h0012);
        want(K_LAPS, 16'd4);

        // Start+stop together stays paused; clear in RUN ignored; reset mid-run.
        up = 1'b1; set = 1'b0;
        cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        want(K_RUN, 16'd0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want(K_RUN, 16'd1);
        want(K_DISP, 16'h0012);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        want(K_RUN, 16'd1);
        want(K_LAPS, 16'd4);
        want(K_VALUE, 16'h0012);
        reset = 1'b1; lap = 1'b1;
        @(negedge clk);
        reset = 1'b0; lap = 1'b0;
        want_reset_state();

        repeat (3) @(negedge clk);
        #2;
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
